adc_poll_scheduler: RTL and testbench
=====================================

ADC_POLL_SCHEDULER -- requirements
Module: adc_poll_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, 8, number of analog-mux channels polled per frame (2..16).
REQ-002 SHALL have parameter SETTLE, 8'd20, clk cycles from mux address change to request.
REQ-003 SHALL have parameter TIMEOUT, 8'd200, clk cycles allowed from request to spiReady.
REQ-004 SHALL have parameter PERIOD, 16'd8000, clk cycles between frame-start ticks.
REQ-005 SHALL have ports clk in 1 system clock (80 MHz); reset in 1 asynchronous, active-high reset.
REQ-006 SHALL have ports enable in 1 frame polling permitted; spiData in 12 word from SPI receiver; spiReady in 1 receiver word-valid strobe.
REQ-007 SHALL have ports dataRequest out 1 request to SPI receiver; muxAddr out 4 analog mux select.
REQ-008 SHALL have ports rdAddr in 4 sample bank read index; rdData out 12 registered bank read data.
REQ-009 SHALL have ports frameReady out 1 one-cycle frame-complete strobe; errMask out 16 per-channel timeout flags of last frame; overrun out 1 sticky missed-tick flag; overrunClr in 1 clears overrun.

Function
REQ-010 SHALL run a free period counter 0..PERIOD-1; tick asserted for one cycle at wrap.
REQ-011 SHALL use states IDLE, SETTLE, REQUEST, WAIT_RDY, STORE, NEXT.
REQ-012 IDLE: on tick with enable=1 SHALL set muxAddr=0, clear working error mask, go SETTLE.
REQ-013 SETTLE: SHALL count SETTLE cycles, then go REQUEST.
REQ-014 REQUEST: SHALL hold dataRequest=1 for exactly 2 cycles, then go WAIT_RDY with timeout counter cleared.
REQ-015 WAIT_RDY: on spiReady=1 SHALL capture spiData into bank[muxAddr], go STORE.
REQ-016 WAIT_RDY: if TIMEOUT cycles elapse without spiReady SHALL write 12'hFFF to bank[muxAddr], set working mask bit muxAddr, go STORE.
REQ-017 spiReady and timeout expiring in the same cycle SHALL be treated as valid data (no error bit).
REQ-018 STORE: SHALL last one cycle, then go NEXT.
REQ-019 NEXT: if muxAddr<CHANNELS-1 SHALL increment muxAddr and go SETTLE; else SHALL copy working mask to errMask, pulse frameReady one cycle, go IDLE.
REQ-020 spiReady outside WAIT_RDY SHALL be ignored.
REQ-021 tick while not in IDLE SHALL be dropped and SHALL set overrun; overrunClr clears it; set wins over simultaneous clear.
REQ-022 enable deasserted mid-frame SHALL not abort; frame completes, no new frame starts.
REQ-023 rdData SHALL equal bank[rdAddr] one cycle after rdAddr is presented; rdAddr>=CHANNELS returns 0; write and read of the same index in one cycle returns old data.
REQ-024 muxAddr SHALL stay constant from SETTLE entry through STORE of that channel.
REQ-025 bit positions of errMask >= CHANNELS SHALL read 0.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, all counters 0, dataRequest=0, muxAddr=0, frameReady=0, errMask=0, overrun=0, rdData=0, bank contents 0.
REQ-027 reset asserted mid-frame SHALL drop the frame with no frameReady; first frame after release SHALL begin at the first tick (PERIOD cycles after release).

Structure
REQ-028 state encodings and the 12'hFFF timeout sentinel SHALL live in the shared adc package.
REQ-029 sample bank plus registered read port SHALL be one sub-module, adc_sample_bank.
REQ-030 SPI receiver SHALL be instantiated outside this block; no SPI pins here.

Verification
REQ-031 PERIOD=100, CHANNELS=4, receiver model answering 30 cycles after request with 12'h100+ch -> bank reads 100,101,102,103; frameReady once; errMask=0.
REQ-032 model never answers channel 2 -> bank[2]=12'hFFF, errMask=16'h0004, frameReady still pulses after channel 3.
REQ-033 PERIOD=50 with 4 channels of SETTLE 20 -> overrun=1 after first frame; overrunClr pulse -> overrun=0 unless same-cycle tick.
REQ-034 spiReady on the exact TIMEOUT cycle -> data stored, error bit clear; stray spiReady during SETTLE -> bank unchanged.
REQ-035 reset pulsed during channel 1 WAIT_RDY -> dataRequest=0, muxAddr=0, no frameReady; next frame starts PERIOD cycles after release.
REQ-036 enable dropped during channel 0 -> frame finishes with frameReady; no further dataRequest for 3 periods.

Source files
------------

// File: rtl/adc_poll_scheduler_pkg.sv
// Shared definitions for the ADC poll scheduler: FSM state encodings,
// the timeout sentinel word and a channel-count bit-mask helper.
package adc_poll_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_STORE    = 3'd4,
    ST_NEXT     = 3'd5
  } adc_state_e;

  localparam logic [11:0] ADC_TIMEOUT_DATA = 12'hFFF;

  // One bit per populated channel; upper bits stay zero.
  function automatic logic [15:0] chan_mask(input int n);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/adc_poll_scheduler_sample_bank.sv
// Per-channel sample store, one write port and a registered read port (1 cycle).
// No flow control; reads of unpopulated indices return zero, same-index read/write returns old data.
module adc_sample_bank
  import adc_poll_scheduler_pkg::*;
#(
  parameter int CHANNELS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [11:0] i_wr_data,
  input  logic [3:0]  i_rd_addr,
  output logic [11:0] o_rd_data
);

  localparam logic [4:0] NCH = 5'(CHANNELS);

  logic [11:0] r_mem [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
      o_rd_data <= '0;
    end else begin
      if (i_wr_en && ({1'b0, i_wr_addr} < NCH)) r_mem[i_wr_addr] <= i_wr_data;
      if ({1'b0, i_rd_addr} < NCH) o_rd_data <= r_mem[i_rd_addr];
      else                         o_rd_data <= '0;
    end
  end

endmodule

// File: rtl/adc_poll_scheduler.sv
// Frame-periodic ADC mux poller: settle, request, wait-with-timeout, store per channel.
// Bank read latency 1 cycle; ticks arriving while a frame is busy are dropped and flagged in overrun.
module adc_poll_scheduler
  import adc_poll_scheduler_pkg::*;
#(
  parameter int          CHANNELS = 8,
  parameter logic [7:0]  SETTLE   = 8'd20,
  parameter logic [7:0]  TIMEOUT  = 8'd200,
  parameter logic [15:0] PERIOD   = 16'd8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] spiData,
  input  logic        spiReady,
  output logic        dataRequest,
  output logic [3:0]  muxAddr,
  input  logic [3:0]  rdAddr,
  output logic [11:0] rdData,
  output logic        frameReady,
  output logic [15:0] errMask,
  output logic        overrun,
  input  logic        overrunClr
);

  localparam logic [15:0] P_LAST  = PERIOD - 16'd1;
  localparam logic [7:0]  S_LAST  = SETTLE - 8'd1;
  localparam logic [7:0]  T_LAST  = TIMEOUT - 8'd1;
  localparam logic [3:0]  LAST_CH = 4'(CHANNELS - 1);
  localparam logic [15:0] CH_MASK = chan_mask(CHANNELS);

  adc_state_e  r_state;
  logic [15:0] r_period;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic [3:0]  r_mux;
  logic        r_frame_rdy;
  logic [15:0] r_work;
  logic [15:0] r_err;
  logic        r_overrun;

  logic        w_tick;
  logic        w_wr_en;
  logic [11:0] w_wr_dat;

  assign w_tick   = (r_period == P_LAST);
  // Data arriving on the expiry cycle itself still counts as a good sample.
  assign w_wr_en  = (r_state == ST_WAIT_RDY) && (spiReady || (r_cnt == T_LAST));
  assign w_wr_dat = spiReady ? spiData : ADC_TIMEOUT_DATA;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_period <= '0;
    else       r_period <= w_tick ? 16'd0 : r_period + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_mux       <= '0;
      r_frame_rdy <= 1'b0;
      r_work      <= '0;
      r_err       <= '0;
    end else begin
      r_frame_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_tick && enable) begin
          r_mux   <= '0;
          r_work  <= '0;
          r_cnt   <= '0;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: if (r_cnt == S_LAST) begin
          r_cnt   <= '0;
          r_req   <= 1'b1;
          r_state <= ST_REQUEST;
        end else r_cnt <= r_cnt + 8'd1;
        ST_REQUEST: if (r_cnt == 8'd1) begin
          r_cnt   <= '0;
          r_req   <= 1'b0;
          r_state <= ST_WAIT_RDY;
        end else r_cnt <= r_cnt + 8'd1;
        ST_WAIT_RDY: if (spiReady) begin
          r_state <= ST_STORE;
        end else if (r_cnt == T_LAST) begin
          r_work[r_mux] <= 1'b1;
          r_state       <= ST_STORE;
        end else r_cnt <= r_cnt + 8'd1;
        ST_STORE: r_state <= ST_NEXT;
        ST_NEXT: if (r_mux < LAST_CH) begin
          r_mux   <= r_mux + 4'd1;
          r_cnt   <= '0;
          r_state <= ST_SETTLE;
        end else begin
          r_err       <= r_work & CH_MASK;
          r_frame_rdy <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_overrun <= 1'b0;
    else if (w_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
    else if (overrunClr)                   r_overrun <= 1'b0;
  end

  adc_sample_bank #(.CHANNELS(CHANNELS)) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_mux),
    .i_wr_data (w_wr_dat),
    .i_rd_addr (rdAddr),
    .o_rd_data (rdData)
  );

  assign dataRequest = r_req;
  assign muxAddr     = r_mux;
  assign frameReady  = r_frame_rdy;
  assign errMask     = r_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_poll_scheduler.sv
// Directed bench: instance A (PERIOD 100) with a delayed-answer receiver model,
// instance B (PERIOD 50, receiver silent) for timeout-everywhere and overrun behaviour.
module tb_adc_poll_scheduler;

  logic        clk;
  logic        reset, enable, overrunClr;
  logic [3:0]  rdAddr;
  wire         spiReady;
  wire  [11:0] spiData;
  logic        dataRequest, frameReady, overrun;
  logic [3:0]  muxAddr;
  logic [11:0] rdData;
  logic [15:0] errMask;

  logic        model_rdy, stray_rdy, model_prev, mon_prev;
  logic [11:0] model_dat, stray_dat, base;
  int          rsp_delay [4];
  int          skip_ch, m_ch;

  logic        rst_b, en_b, clr_b, spiReady_b;
  logic [11:0] spiData_b, rdData_b;
  logic [3:0]  rdAddr_b, muxAddr_b;
  logic        dataRequest_b, frameReady_b, overrun_b;
  logic [15:0] errMask_b;

  int checks, failures, fr_cnt, req_cnt;
  int k, fr0, r1;
  logic found;

  assign spiReady = model_rdy | stray_rdy;
  assign spiData  = model_rdy ? model_dat : stray_dat;

  adc_poll_scheduler #(.CHANNELS(4), .SETTLE(8'd20), .TIMEOUT(8'd40), .PERIOD(16'd100)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .spiData(spiData), .spiReady(spiReady),
    .dataRequest(dataRequest), .muxAddr(muxAddr), .rdAddr(rdAddr), .rdData(rdData),
    .frameReady(frameReady), .errMask(errMask), .overrun(overrun), .overrunClr(overrunClr)
  );

  adc_poll_scheduler #(.CHANNELS(4), .SETTLE(8'd20), .TIMEOUT(8'd40), .PERIOD(16'd50)) u_dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .spiData(spiData_b), .spiReady(spiReady_b),
    .dataRequest(dataRequest_b), .muxAddr(muxAddr_b), .rdAddr(rdAddr_b), .rdData(rdData_b),
    .frameReady(frameReady_b), .errMask(errMask_b), .overrun(overrun_b), .overrunClr(clr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [11:0] exp);
    rdAddr = a;
    @(negedge clk);
    chk(tag, {20'd0, rdData}, {20'd0, exp});
  endtask

  task automatic wait_frame(input string tag, input int max);
    int n;
    n = 0;
    while (!frameReady && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, frameReady}, 32'd1);
  endtask

  task automatic wait_mux1(input string tag, input int max);
    int n;
    n = 0;
    while (muxAddr != 4'd1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {28'd0, muxAddr}, 32'd1);
  endtask

  // Receiver model: answers base+channel a per-channel number of cycles after the request rises.
  initial begin
    model_rdy = 1'b0; model_dat = '0; model_prev = 1'b0; m_ch = 0;
    forever begin
      @(negedge clk);
      if (dataRequest && !model_prev) begin
        m_ch = int'(muxAddr);
        if (m_ch != skip_ch) begin
          repeat (rsp_delay[m_ch & 3]) @(negedge clk);
          model_dat = base + 12'(m_ch);
          model_rdy = 1'b1;
          @(negedge clk);
          model_rdy = 1'b0;
        end
      end
      model_prev = dataRequest;
    end
  end

  initial begin
    fr_cnt = 0; req_cnt = 0; mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frameReady) fr_cnt++;
      if (dataRequest && !mon_prev) req_cnt++;
      mon_prev = dataRequest;
    end
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; enable = 1'b0; rdAddr = '0; overrunClr = 1'b0;
    stray_rdy = 1'b0; stray_dat = '0;
    rst_b = 1'b1; en_b = 1'b0; rdAddr_b = '0; clr_b = 1'b0; spiReady_b = 1'b0; spiData_b = '0;
    base = 12'h100; skip_ch = 15; rsp_delay = '{30, 30, 30, 30};
    repeat (3) @(negedge clk);

    chk("rst_dataRequest", {31'd0, dataRequest}, 32'd0);
    chk("rst_muxAddr", {28'd0, muxAddr}, 32'd0);
    chk("rst_frameReady", {31'd0, frameReady}, 32'd0);
    chk("rst_errMask", {16'd0, errMask}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_rdData", {20'd0, rdData}, 32'd0);

    // Instance B: every channel times out, frame spans several 50-cycle ticks.
    en_b = 1'b1; rst_b = 1'b0; k = 0;
    while (!frameReady_b && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("b_frame_len", k, 32'd306);
    chk("b_errMask", {16'd0, errMask_b}, 32'h000F);
    chk("b_overrun_after_frame", {31'd0, overrun_b}, 32'd1);
    rdAddr_b = 4'd2;
    @(negedge clk);
    chk("b_bank2_timeout", {20'd0, rdData_b}, 32'hFFF);
    rdAddr_b = 4'd5;
    @(negedge clk);
    chk("b_bank5_oob", {20'd0, rdData_b}, 32'd0);
    repeat (91) @(negedge clk);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("b_overrun_set_wins", {31'd0, overrun_b}, 32'd1);
    repeat (4) @(negedge clk);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("b_overrun_cleared", {31'd0, overrun_b}, 32'd0);
    repeat (45) @(negedge clk);
    chk("b_overrun_reset_by_tick", {31'd0, overrun_b}, 32'd1);
    rst_b = 1'b1; en_b = 1'b0;

    // Frame 1: all channels answered after 30 cycles.
    enable = 1'b1; rdAddr = 4'd3; fr0 = fr_cnt;
    reset = 1'b0; k = 0;
    while (!dataRequest && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("a_first_req_delay", k, 32'd120);
    wait_frame("a_f1_done", 400);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("a_f1_frame_count", fr_cnt - fr0, 32'd1);
    chk("a_f1_errMask", {16'd0, errMask}, 32'd0);
    chk("a_f1_overrun", {31'd0, overrun}, 32'd1);
    overrunClr = 1'b1;
    @(negedge clk);
    overrunClr = 1'b0;
    chk("a_overrun_clr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("a_f1_bank%0d", i), 4'(i), 12'h100 + 12'(i));
    rd_chk("a_bank4_oob", 4'd4, 12'h000);
    rd_chk("a_bank15_oob", 4'd15, 12'h000);

    // Frame 2: channel 2 never answered, enable dropped during channel 0.
    base = 12'h200; skip_ch = 2; enable = 1'b1; k = 0;
    while (!dataRequest && k < 300) begin
      @(negedge clk);
      k++;
    end
    enable = 1'b0;
    rdAddr = 4'd1; k = 0; found = 1'b0;
    while (!found && k < 400) begin
      @(negedge clk);
      #1;
      k++;
      if (spiReady && muxAddr == 4'd1) found = 1'b1;
    end
    chk("a_f2_ch1_answer_seen", {31'd0, found}, 32'd1);
    @(negedge clk);
    chk("a_rdw_old_data", {20'd0, rdData}, 32'h101);
    @(negedge clk);
    chk("a_rdw_new_data", {20'd0, rdData}, 32'h201);
    wait_frame("a_f2_done", 400);
    repeat (2) @(negedge clk);
    chk("a_f2_errMask", {16'd0, errMask}, 32'h0004);
    rd_chk("a_f2_bank0", 4'd0, 12'h200);
    rd_chk("a_f2_bank2", 4'd2, 12'hFFF);
    rd_chk("a_f2_bank3", 4'd3, 12'h203);
    r1 = req_cnt;
    repeat (300) @(negedge clk);
    chk("a_no_req_after_disable", req_cnt - r1, 32'd0);

    // Frame 3: exact-expiry answer on ch0, one-cycle-late answer on ch1, stray strobes.
    stray_dat = 12'hABC; stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    rd_chk("a_stray_idle", 4'd0, 12'h200);
    base = 12'h300; skip_ch = 15; rsp_delay = '{41, 42, 30, 30};
    enable = 1'b1;
    wait_mux1("a_f3_ch1_start", 400);
    enable = 1'b0; stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    rd_chk("a_stray_settle", 4'd1, 12'h201);
    wait_frame("a_f3_done", 400);
    repeat (2) @(negedge clk);
    chk("a_f3_errMask", {16'd0, errMask}, 32'h0002);
    rd_chk("a_f3_bank0_exact", 4'd0, 12'h300);
    rd_chk("a_f3_bank1_late", 4'd1, 12'hFFF);
    rd_chk("a_f3_bank3", 4'd3, 12'h303);

    // Frame 4: reset during channel 1 wait.
    base = 12'h400; rsp_delay = '{30, 30, 30, 30};
    enable = 1'b1;
    wait_mux1("a_f4_ch1_start", 400);
    repeat (25) @(negedge clk);
    fr0 = fr_cnt;
    reset = 1'b1;
    #1;
    chk("a_async_rst_muxAddr", {28'd0, muxAddr}, 32'd0);
    chk("a_async_rst_dataRequest", {31'd0, dataRequest}, 32'd0);
    chk("a_async_rst_errMask", {16'd0, errMask}, 32'd0);
    chk("a_async_rst_rdData", {20'd0, rdData}, 32'd0);
    rdAddr = 4'd3;
    repeat (3) @(negedge clk);
    reset = 1'b0; k = 0;
    while (!dataRequest && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("a_req_delay_after_reset", k, 32'd120);
    chk("a_bank_cleared_by_reset", {20'd0, rdData}, 32'd0);
    chk("a_no_frame_on_reset", fr_cnt - fr0, 32'd0);
    enable = 1'b0;
    wait_frame("a_f4_done", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
